// File: rtl/hierInclude_package.sv
// Shared event-handler types and system constants used by the blockA merge stage.
package hierInclude_package;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
  } aSt;

  localparam int AH_ARB_DEPTH = 2;

  typedef enum logic {
    PRIO_SRC0 = 1'b0,
    PRIO_SRC1 = 1'b1
  } prio_e;

endpackage

// File: rtl/eh_arb_fifo.sv
// DEPTH-entry registered circular FIFO for the arbiter output; no push-to-pop bypass.
module eh_arb_fifo
  import hierInclude_package::*;
#(
  parameter int DEPTH = AH_ARB_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  aSt   push_data,
  input  logic pop,
  output aSt   pop_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  aSt               mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is cleared on reset so the output payload reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/eh_rdy_vld_arbiter.sv
// Two-source round-robin rdy/vld merge into blockA, with registered output FIFO and per-source accept counters.
module eh_rdy_vld_arbiter
  import hierInclude_package::*;
#(
  parameter int DEPTH = AH_ARB_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src0_vld,
  output logic             src0_rdy,
  input  aSt               src0_data,
  input  logic             src1_vld,
  output logic             src1_rdy,
  input  aSt               src1_data,
  output logic             dst_vld,
  input  logic             dst_rdy,
  output aSt               dst_data,
  output logic [CNT_W-1:0] acc_cnt0,
  output logic [CNT_W-1:0] acc_cnt1
);

  if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
    $error("eh_rdy_vld_arbiter: DEPTH must be within 2..8");
  end

  prio_e prio;
  logic  full;
  logic  empty;
  logic  space;
  logic  acc0;
  logic  acc1;
  aSt    push_data;

  // Space ignores a same-cycle pop so ready never depends on dst_rdy.
  assign space    = !full;
  assign src0_rdy = !rst && space && (prio == PRIO_SRC0 || !src1_vld);
  assign src1_rdy = !rst && space && (prio == PRIO_SRC1 || !src0_vld);
  assign acc0     = src0_vld && src0_rdy;
  assign acc1     = src1_vld && src1_rdy;
  assign push_data = acc0 ? src0_data : src1_data;
  assign dst_vld  = !empty;

  eh_arb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (acc0 || acc1),
    .push_data(push_data),
    .pop      (dst_vld && dst_rdy),
    .pop_data (dst_data),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= PRIO_SRC0;
      acc_cnt0 <= '0;
      acc_cnt1 <= '0;
    end else if (acc0) begin
      prio     <= PRIO_SRC1;
      acc_cnt0 <= acc_cnt0 + CNT_W'(1);
    end else if (acc1) begin
      prio     <= PRIO_SRC0;
      acc_cnt1 <= acc_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_eh_rdy_vld_arbiter.sv
// Bench for eh_rdy_vld_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_eh_rdy_vld_arbiter;
  import hierInclude_package::*;

  localparam int DEPTH = AH_ARB_DEPTH;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             src0_vld;
  logic             src0_rdy;
  aSt               src0_data;
  logic             src1_vld;
  logic             src1_rdy;
  aSt               src1_data;
  logic             dst_vld;
  logic             dst_rdy;
  aSt               dst_data;
  logic [CNT_W-1:0] acc_cnt0;
  logic [CNT_W-1:0] acc_cnt1;

  always #5 clk = ~clk;

  eh_rdy_vld_arbiter #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src0_vld (src0_vld),
    .src0_rdy (src0_rdy),
    .src0_data(src0_data),
    .src1_vld (src1_vld),
    .src1_rdy (src1_rdy),
    .src1_data(src1_data),
    .dst_vld  (dst_vld),
    .dst_rdy  (dst_rdy),
    .dst_data (dst_data),
    .acc_cnt0 (acc_cnt0),
    .acc_cnt1 (acc_cnt1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffered beats in acceptance order, whose turn it is, and accept totals.
  aSt          mq[$];
  aSt          dut_popped[$];
  bit          turn1;
  int unsigned mc0;
  int unsigned mc1;
  logic        la0;
  logic        la1;

  // DUT observations captured at the sample point of the latest step.
  logic [CNT_W-1:0] samp_c0;
  logic [CNT_W-1:0] samp_c1;
  int               obs_src;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic aSt mk(input logic [7:0] tag, input int idx);
    return aSt'({8'h5A, idx[15:0], tag});
  endfunction

  task automatic step(input logic r, input logic v0, input aSt d0,
                      input logic v1, input aSt d1, input logic dr);
    bit room;
    bit win0;
    bit win1;
    @(negedge clk);
    rst = r; src0_vld = v0; src0_data = d0; src1_vld = v1; src1_data = d1; dst_rdy = dr;
    #1;
    room = (mq.size() < DEPTH);
    // A source is offered ready when there is room and it would win arbitration if it were valid.
    win0 = !r && room && (!turn1 || !v1);
    win1 = !r && room && (turn1 || !v0);
    check_eq("src0_rdy", src0_rdy, win0);
    check_eq("src1_rdy", src1_rdy, win1);
    check_eq("dst_vld", dst_vld, mq.size() != 0);
    if (mq.size() != 0) check_eq("dst_data", dst_data, mq[0]);
    check_eq("acc_cnt0", acc_cnt0, mc0);
    check_eq("acc_cnt1", acc_cnt1, mc1);
    samp_c0 = acc_cnt0;
    samp_c1 = acc_cnt1;
    obs_src = (src0_vld && src0_rdy) ? 0 : ((src1_vld && src1_rdy) ? 1 : -1);
    if (!r && dst_vld && dst_rdy) dut_popped.push_back(dst_data);
    la0 = v0 && win0;
    la1 = v1 && win1 && !la0;
    @(posedge clk);
    if (r) begin
      mq.delete();
      turn1 = 1'b0;
      mc0 = 0;
      mc1 = 0;
      la0 = 1'b0;
      la1 = 1'b0;
    end else begin
      if (mq.size() != 0 && dr) void'(mq.pop_front());
      if (la0) begin
        mq.push_back(d0);
        mc0 = (mc0 + 1) % 65536;
        turn1 = 1'b1;
      end else if (la1) begin
        mq.push_back(d1);
        mc1 = (mc1 + 1) % 65536;
        turn1 = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic dr);
    step(1'b0, 1'b0, '0, 1'b0, '0, dr);
  endtask

  int   i0;
  int   i1;
  int   base;
  int   mark;
  int   ghost;
  logic p0v;
  logic p1v;
  aSt   p0d;
  aSt   p1d;
  logic rr;

  initial begin
    rst = 1'b1; src0_vld = 1'b0; src1_vld = 1'b0; src0_data = '0; src1_data = '0; dst_rdy = 1'b0;
    turn1 = 1'b0; mc0 = 0; mc1 = 0;
    repeat (2) @(posedge clk);

    // Reset state and idle readiness.
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    check_eq("t1_dst_data_reset", dst_data, 0);
    idle(1'b0);
    idle(1'b0);

    // Both sources streaming: strict alternation starting with source 0.
    i0 = 0; i1 = 0;
    dut_popped.delete();
    for (int c = 0; c < 40 && (i0 + i1) < 8; c++) begin
      step(1'b0, 1'b1, mk(8'hA0 + 8'(i0), i0), 1'b1, mk(8'hB0 + 8'(i1), i1), 1'b1);
      if (la0) i0++;
      if (la1) i1++;
    end
    repeat (3) idle(1'b1);
    check_eq("t2_acc_cnt0", samp_c0, 4);
    check_eq("t2_acc_cnt1", samp_c1, 4);
    check_eq("t2_npop", dut_popped.size(), 8);
    for (int k = 0; k < dut_popped.size() && k < 8; k++)
      check_eq($sformatf("t2_order%0d", k), dut_popped[k].data,
               (k % 2 == 0) ? 8'hA0 + 8'(k / 2) : 8'hB0 + 8'(k / 2));

    // Only source 1 active: keeps making progress.
    base = int'(samp_c1);
    i1 = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, '0, 1'b1, mk(8'hC0 + 8'(i1), i1), 1'b1);
      if (la1) i1++;
    end
    idle(1'b1);
    check_eq("t3_progress", (int'(samp_c1) - base) >= 5, 1);
    repeat (2) idle(1'b1);

    // Downstream stalled: fill to DEPTH, then one pop reopens space for the other source.
    base = int'(samp_c0) + int'(samp_c1);
    i0 = 0; i1 = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1, mk(8'hD0 + 8'(i0), i0), 1'b1, mk(8'hE0 + 8'(i1), i1), 1'b0);
      if (la0) i0++;
      if (la1) i1++;
    end
    step(1'b0, 1'b1, mk(8'hD0 + 8'(i0), i0), 1'b1, mk(8'hE0 + 8'(i1), i1), 1'b1);
    check_eq("t4_fill_count", int'(samp_c0) + int'(samp_c1) - base, DEPTH);
    check_eq("t4_full_rdy0", src0_rdy, 0);
    step(1'b0, 1'b1, mk(8'hD0 + 8'(i0), i0), 1'b1, mk(8'hE0 + 8'(i1), i1), 1'b0);
    check_eq("t4_next_src", obs_src, 0);
    if (la0) i0++;
    if (la1) i1++;
    repeat (4) idle(1'b1);

    // Counter wrap at all-ones.
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int c = 0; c < 70000 && mc0 < 65535; c++)
      step(1'b0, 1'b1, mk(8'h30, int'(mc0)), 1'b0, '0, 1'b1);
    idle(1'b1);
    check_eq("t5_cnt_ffff", samp_c0, 16'hFFFF);
    step(1'b0, 1'b1, mk(8'h31, 0), 1'b0, '0, 1'b1);
    idle(1'b1);
    check_eq("t5_cnt_wrap", samp_c0, 16'h0000);
    check_eq("t5_cnt1_untouched", samp_c1, 0);
    repeat (2) idle(1'b1);

    // Reset with a full FIFO discards the buffered beats and the beat offered during reset.
    i0 = 0; i1 = 0;
    for (int c = 0; c < 6 && mq.size() < DEPTH; c++) begin
      step(1'b0, 1'b1, mk(8'h70 + 8'(i0), i0), 1'b1, mk(8'h80 + 8'(i1), i1), 1'b0);
      if (la0) i0++;
      if (la1) i1++;
    end
    step(1'b1, 1'b1, mk(8'hEE, 0), 1'b0, '0, 1'b0);
    mark = dut_popped.size();
    idle(1'b1);
    check_eq("t6_dst_vld", dst_vld, 0);
    check_eq("t6_cnt0", samp_c0, 0);
    check_eq("t6_cnt1", samp_c1, 0);
    repeat (4) idle(1'b1);
    ghost = 0;
    for (int k = mark; k < dut_popped.size(); k++) ghost++;
    check_eq("t6_no_ghost", ghost, 0);

    // Random traffic honouring the hold-until-accepted rule.
    p0v = 1'b0; p1v = 1'b0; p0d = '0; p1d = '0;
    for (int c = 0; c < 400; c++) begin
      rr = ($urandom_range(0, 99) == 0);
      if (!p0v) begin p0v = ($urandom_range(0, 1) != 0); p0d = aSt'($urandom); end
      if (!p1v) begin p1v = ($urandom_range(0, 1) != 0); p1d = aSt'($urandom); end
      step(rr, p0v, p0d, p1v, p1d, $urandom_range(0, 3) != 0);
      if (la0 || rr) p0v = 1'b0;
      if (la1 || rr) p1v = 1'b0;
    end
    repeat (4) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
